// File: rtl/alu_rs_if.sv
// alu_rs_if: issue, CDB snoop, FU dispatch and writeback signals of the ALU reservation station.
interface alu_rs_if #(parameter int TAG_W = 5);
    logic             issue_valid;
    logic             issue_ready;
    logic [3:0]       issue_ctrl;
    logic [TAG_W-1:0] issue_tag;
    logic [TAG_W-1:0] issue_qj;
    logic [TAG_W-1:0] issue_qk;
    logic [31:0]      issue_vj;
    logic [31:0]      issue_vk;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             fu_en;
    logic [3:0]       fu_ctrl;
    logic [31:0]      fu_a;
    logic [31:0]      fu_b;
    logic             fu_finish;
    logic [31:0]      fu_res;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             wb_ready;

    modport slave (
        input  issue_valid, issue_ctrl, issue_tag, issue_qj, issue_qk, issue_vj, issue_vk,
        input  cdb_valid, cdb_tag, cdb_data, fu_finish, fu_res, wb_ready,
        output issue_ready, fu_en, fu_ctrl, fu_a, fu_b, wb_valid, wb_tag, wb_data
    );

    modport master (
        output issue_valid, issue_ctrl, issue_tag, issue_qj, issue_qk, issue_vj, issue_vk,
        output cdb_valid, cdb_tag, cdb_data, fu_finish, fu_res, wb_ready,
        input  issue_ready, fu_en, fu_ctrl, fu_a, fu_b, wb_valid, wb_tag, wb_data
    );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: single-FU reservation station with CDB snooping, one-pulse dispatch and a one-entry writeback register.
module alu_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input logic     clk,
    input logic     rst,
    alu_rs_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic             valid;
        logic [3:0]       ctrl;
        logic [TAG_W-1:0] tag;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vj;
        logic [31:0]      vk;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    state_t           state_q, state_d;
    logic             fu_en_q, fu_en_d;
    logic [3:0]       fu_ctrl_q, fu_ctrl_d;
    logic [31:0]      fu_a_q, fu_a_d;
    logic [31:0]      fu_b_q, fu_b_d;
    logic [TAG_W-1:0] hold_tag_q, hold_tag_d;
    logic             wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic [31:0]      wb_data_q, wb_data_d;

    logic [IW-1:0] free_idx, sel_idx;
    logic          has_free, has_rdy;
    logic          accept, cdb_hit, dispatch, capture;
    logic          byp_j, byp_k;

    // Downward scan so the last hit is the lowest index.
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        has_free = 1'b0;
        has_rdy  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                free_idx = IW'(i);
                has_free = 1'b1;
            end
            if (ent_q[i].valid && ent_q[i].qj == '0 && ent_q[i].qk == '0) begin
                sel_idx = IW'(i);
                has_rdy = 1'b1;
            end
        end
    end

    assign accept   = bus.issue_valid && has_free;
    assign cdb_hit  = bus.cdb_valid && bus.cdb_tag != '0;
    assign byp_j    = cdb_hit && bus.issue_qj == bus.cdb_tag;
    assign byp_k    = cdb_hit && bus.issue_qk == bus.cdb_tag;
    assign dispatch = state_q == IDLE && has_rdy && (!wb_valid_q || bus.wb_ready);
    assign capture  = state_q == BUSY && bus.fu_finish;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (cdb_hit && ent_q[i].valid && ent_q[i].qj == bus.cdb_tag) begin
                ent_d[i].qj = '0;
                ent_d[i].vj = bus.cdb_data;
            end
            if (cdb_hit && ent_q[i].valid && ent_q[i].qk == bus.cdb_tag) begin
                ent_d[i].qk = '0;
                ent_d[i].vk = bus.cdb_data;
            end
            if (dispatch && sel_idx == IW'(i))
                ent_d[i].valid = 1'b0;
            if (accept && free_idx == IW'(i)) begin
                ent_d[i].valid = 1'b1;
                ent_d[i].ctrl  = bus.issue_ctrl;
                ent_d[i].tag   = bus.issue_tag;
                ent_d[i].qj    = byp_j ? '0 : bus.issue_qj;
                ent_d[i].vj    = byp_j ? bus.cdb_data : bus.issue_vj;
                ent_d[i].qk    = byp_k ? '0 : bus.issue_qk;
                ent_d[i].vk    = byp_k ? bus.cdb_data : bus.issue_vk;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = dispatch ? BUSY : capture ? IDLE : state_q;
    end

    always_comb begin
        fu_en_d    = dispatch;
        fu_ctrl_d  = dispatch ? ent_q[sel_idx].ctrl : fu_ctrl_q;
        fu_a_d     = dispatch ? ent_q[sel_idx].vj : fu_a_q;
        fu_b_d     = dispatch ? ent_q[sel_idx].vk : fu_b_q;
        hold_tag_d = dispatch ? ent_q[sel_idx].tag : hold_tag_q;
        wb_valid_d = capture || (wb_valid_q && !bus.wb_ready);
        wb_tag_d   = capture ? hold_tag_q : wb_tag_q;
        wb_data_d  = capture ? bus.fu_res : wb_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
            fu_en_q    <= 1'b0;
            fu_ctrl_q  <= '0;
            fu_a_q     <= '0;
            fu_b_q     <= '0;
            hold_tag_q <= '0;
            wb_valid_q <= 1'b0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= ent_d[i];
            fu_en_q    <= fu_en_d;
            fu_ctrl_q  <= fu_ctrl_d;
            fu_a_q     <= fu_a_d;
            fu_b_q     <= fu_b_d;
            hold_tag_q <= hold_tag_d;
            wb_valid_q <= wb_valid_d;
            wb_tag_q   <= wb_tag_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign bus.issue_ready = has_free;
    assign bus.fu_en       = fu_en_q;
    assign bus.fu_ctrl     = fu_ctrl_q;
    assign bus.fu_a        = fu_a_q;
    assign bus.fu_b        = fu_b_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_tag      = wb_tag_q;
    assign bus.wb_data     = wb_data_q;
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed and randomized scoreboard bench for alu_rs with a one-cycle FU model.
module tb_alu_rs;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_rs_if #(.TAG_W(TAG_W)) bus ();
    alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [3:0]       ctrl;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vj;
        logic [31:0]      vk;
    } op_t;

    op_t sb[$];

    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            default: return a + b + 32'(c);
        endcase
    endfunction

    function automatic bit tag_busy(input logic [TAG_W-1:0] t);
        foreach (sb[i]) if (sb[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    // FU: latches operands on the edge after fu_en and reports the result for one cycle.
    logic        en_s = 1'b0, fin_m = 1'b0, fin_force = 1'b0;
    logic [31:0] res_s = '0, res_m = '0;
    always @(negedge clk) begin
        en_s = bus.fu_en;
        res_s = alu_f(bus.fu_ctrl, bus.fu_a, bus.fu_b);
    end
    always @(posedge clk) begin
        #1;
        fin_m = en_s;
        res_m = res_s;
    end
    assign bus.fu_finish = fin_m | fin_force;
    assign bus.fu_res = res_m;

    int cyc = 0, en_cnt = 0, last_en = -10;
    logic [31:0] disp_b[$];

    always @(negedge clk) begin
        int idx;
        cyc++;
        if (rst && bus.fu_en) begin
            chk("fu_en_gap>=3", 32'(cyc - last_en >= 3), 32'd1);
            last_en = cyc;
            en_cnt++;
            disp_b.push_back(bus.fu_b);
        end
        if (rst && bus.wb_valid && bus.wb_ready) begin
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].tag == bus.wb_tag) idx = i;
            if (idx < 0) begin
                checks++;
                failures++;
                $display("FAIL wb_tag: got %0d expected an outstanding tag", bus.wb_tag);
            end else begin
                chk("wb_data", bus.wb_data, alu_f(sb[idx].ctrl, sb[idx].vj, sb[idx].vk));
                sb.delete(idx);
            end
        end
    end

    task automatic step(input logic iv, input logic [3:0] c, input logic [TAG_W-1:0] t,
                        input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                        input logic [31:0] vj, input logic [31:0] vk,
                        input logic cv, input logic [TAG_W-1:0] ct, input logic [31:0] cd);
        bus.issue_valid = iv;
        bus.issue_ctrl = c;
        bus.issue_tag = t;
        bus.issue_qj = qj;
        bus.issue_qk = qk;
        bus.issue_vj = vj;
        bus.issue_vk = vk;
        bus.cdb_valid = cv;
        bus.cdb_tag = ct;
        bus.cdb_data = cd;
        if (iv && bus.issue_ready) sb.push_back('{t, c, qj, qk, vj, vk});
        if (cv && ct != 0)
            foreach (sb[i]) begin
                if (sb[i].qj == ct) begin sb[i].qj = 0; sb[i].vj = cd; end
                if (sb[i].qk == ct) begin sb[i].qk = 0; sb[i].vk = cd; end
            end
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
        bus.cdb_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() > 0; i++) idle(1);
        chk("drain_outstanding", 32'(sb.size()), 32'd0);
        idle(2);
    endtask

    initial begin
        int e0, nb;
        logic [TAG_W-1:0] nt;
        bus.issue_valid = 0; bus.issue_ctrl = 0; bus.issue_tag = 0; bus.issue_qj = 0;
        bus.issue_qk = 0; bus.issue_vj = 0; bus.issue_vk = 0; bus.cdb_valid = 0;
        bus.cdb_tag = 0; bus.cdb_data = 0; bus.wb_ready = 1;
        nt = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl_flags", {bus.fu_en, bus.fu_ctrl, bus.wb_valid, 5'(bus.wb_tag)}, 0);
        chk("rst_fu_a", bus.fu_a, 0);
        chk("rst_fu_b", bus.fu_b, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_issue_ready", bus.issue_ready, 1);
        rst = 1'b1;
        idle(1);
        fin_force = 1'b1;
        idle(1);
        fin_force = 1'b0;
        idle(2);
        chk("idle_finish_ignored", bus.wb_valid, 0);

        step(1, 4'd1, 3, 0, 0, 5, 7, 0, 0, 0);
        chk("add_e0_en", bus.fu_en, 0);
        idle(1);
        chk("add_e1_en", bus.fu_en, 1);
        chk("add_fu_a", bus.fu_a, 5);
        chk("add_fu_b", bus.fu_b, 7);
        idle(1);
        chk("add_e2_en", bus.fu_en, 0);
        chk("add_e2_wbv", bus.wb_valid, 0);
        idle(1);
        chk("add_wb_valid", bus.wb_valid, 1);
        chk("add_wb_tag", bus.wb_tag, 3);
        chk("add_wb_data", bus.wb_data, 12);
        idle(1);
        chk("add_wb_clear", bus.wb_valid, 0);
        drain();

        step(1, 4'd1, 4, 6, 0, 0, 1, 0, 0, 0);
        chk("dep_e0_en", bus.fu_en, 0);
        idle(1);
        chk("dep_e1_en", bus.fu_en, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 6, 10);
        chk("dep_e2_en", bus.fu_en, 0);
        idle(1);
        chk("dep_e3_en", bus.fu_en, 1);
        chk("dep_fu_a", bus.fu_a, 10);
        chk("dep_fu_b", bus.fu_b, 1);
        drain();

        step(1, 4'd2, 5, 0, 9, 3, 32'hdead, 1, 9, 32'hFFFF0000);
        chk("byp_e0_en", bus.fu_en, 0);
        idle(1);
        chk("byp_e1_en", bus.fu_en, 1);
        chk("byp_fu_b", bus.fu_b, 32'hFFFF0000);
        drain();

        for (int k = 0; k < DEPTH; k++) step(1, 4'(k + 1), 5'(8 + k), 7, 0, 32'(100 + k), 32'(10 + k), 0, 0, 0);
        chk("full_ready", bus.issue_ready, 0);
        step(1, 4'd1, 13, 0, 0, 1, 1, 0, 0, 0);
        chk("full_drop_ready", bus.issue_ready, 0);
        nb = disp_b.size();
        e0 = en_cnt;
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h50);
        drain();
        chk("full_dispatch_cnt", 32'(en_cnt - e0), DEPTH);
        for (int k = 0; k < DEPTH; k++) chk("full_order_fu_b", disp_b[nb + k], 32'(10 + k));

        bus.wb_ready = 1'b0;
        step(1, 4'd1, 1, 0, 0, 1, 2, 0, 0, 0);
        step(1, 4'd3, 2, 0, 0, 7, 3, 0, 0, 0);
        idle(6);
        chk("bp_wb_valid", bus.wb_valid, 1);
        chk("bp_wb_tag", bus.wb_tag, 1);
        chk("bp_wb_data", bus.wb_data, 3);
        e0 = en_cnt;
        idle(3);
        chk("bp_hold_valid", bus.wb_valid, 1);
        chk("bp_hold_data", bus.wb_data, 3);
        chk("bp_no_second_en", 32'(en_cnt - e0), 0);
        bus.wb_ready = 1'b1;
        idle(1);
        chk("bp_second_en", bus.fu_en, 1);
        chk("bp_second_fu_b", bus.fu_b, 3);
        chk("bp_consumed", bus.wb_valid, 0);
        drain();

        for (int r = 0; r < 8; r++) begin
            bit bc[8];
            foreach (bc[t]) bc[t] = 1'b0;
            for (int cy = 0; cy < 40; cy++) begin
                logic iv, cv;
                logic [TAG_W-1:0] qj, qk, ct;
                int bt, sel;
                bus.wb_ready = ($urandom % 4) != 0;
                iv = $urandom % 2;
                bt = $urandom % 8;
                qj = ($urandom % 2 && !bc[bt]) ? 5'(16 + bt) : 5'd0;
                bt = $urandom % 8;
                qk = ($urandom % 2 && !bc[bt]) ? 5'(16 + bt) : 5'd0;
                if (iv) do nt = 5'((nt % 15) + 1); while (tag_busy(nt));
                cv = 1'b0;
                ct = 0;
                sel = $urandom % 6;
                if (sel < 2) begin
                    bt = $urandom % 8;
                    if (!bc[bt]) begin cv = 1'b1; ct = 5'(16 + bt); bc[bt] = 1'b1; end
                end else if (sel == 2) begin
                    cv = 1'b1;
                end else if (sel == 3) begin
                    cv = 1'b1;
                    ct = 5'(24 + $urandom % 8);
                end
                step(iv, 4'($urandom), nt, qj, qk, $urandom, $urandom, cv, ct, $urandom);
            end
            for (int t = 0; t < 8; t++) if (!bc[t]) step(0, 0, 0, 0, 0, 0, 0, 1, 5'(16 + t), $urandom);
            drain();
        end

        step(1, 4'd1, 7, 0, 0, 1, 1, 0, 0, 0);
        idle(1);
        rst = 1'b0;
        #1;
        chk("mid_rst_fu_en", bus.fu_en, 0);
        chk("mid_rst_ready", bus.issue_ready, 1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(4);
        chk("post_rst_wb_valid", bus.wb_valid, 0);
        chk("post_rst_ready", bus.issue_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
# alu_rs

Single-FU reservation station sitting directly upstream of the ALU functional unit. It accepts issued ALU operations with renamed operands, snoops the common data bus (CDB) to resolve pending operands, and dispatches ready operations to the FU with a one-cycle `EN` pulse. It captures the FU result on `finish` into a one-entry writeback register and presents it to the CDB arbiter.

## Interface
- DEPTH, 4: number of station entries (2..8)
- TAG_W, 5: producer tag width; tag 0 reserved = "operand value present"
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  issue request this cycle
- issue_ready  out  1  at least one free entry (from registered state)
- issue_ctrl  in  4  ALU control code, passed through unchanged
- issue_tag  in  TAG_W  destination tag, must be nonzero
- issue_qj, issue_qk  in  TAG_W  producer tags of A/B; 0 = value valid
- issue_vj, issue_vk  in  32  A/B values, used when matching q is 0
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag; tag 0 is ignored
- cdb_data  in  32  broadcast value
- fu_en  out  1  one-cycle dispatch pulse to FU
- fu_ctrl  out  4  control to FU
- fu_a, fu_b  out  32  operands to FU
- fu_finish  in  1  FU result valid
- fu_res  in  32  FU result
- wb_valid  out  1  result pending for CDB
- wb_tag  out  TAG_W  tag of pending result
- wb_data  out  32  pending result
- wb_ready  in  1  CDB grant; result is consumed on an edge where wb_valid and wb_ready are both 1

## Operation
- Entry fields: valid, ctrl, tag, qj, vj, qk, vk. Entry ready = valid && qj==0 && qk==0.
- Issue: on an edge where issue_valid && issue_ready, write the lowest-index free entry. issue_valid while !issue_ready is dropped, with no state change.
- Issue bypass: if cdb_valid and cdb_tag equals nonzero issue_qj or issue_qk on the same edge, store cdb_data and clear that q.
- Snoop: every valid entry with qj (qk) == nonzero cdb_tag on a cdb_valid edge loads vj (vk) and clears qj (qk).
- FU control FSM has states IDLE and BUSY.
  - IDLE -> BUSY when some entry is ready && (!wb_valid || wb_ready). Selects the lowest-index ready entry. On that edge: fu_en<=1, fu_ctrl/fu_a/fu_b<=entry, entry freed, tag held internally.
  - BUSY: fu_en<=0 after its single cycle. fu_ctrl/a/b hold stable.
  - BUSY -> IDLE on an edge with fu_finish=1. On that edge: wb_valid<=1, wb_tag<=held tag, wb_data<=fu_res.
- fu_finish while IDLE is ignored. This covers a stale FU pulse after reset.
- wb_valid clears on the consume edge unless a capture occurs on the same edge. The dispatch rule makes capture and consume on the same edge unreachable.
- Entries become ready one cycle after a CDB capture. Readiness is evaluated from registered state only.
- A freed entry is reusable next cycle. issue_ready is not combinationally raised by a same-cycle dispatch.

## Timing
- Reset (asynchronous assert, synchronous-safe release) values:
  - all entries invalid, FSM=IDLE
  - fu_en=0, fu_ctrl=0, fu_a=0, fu_b=0
  - wb_valid=0, wb_tag=0, wb_data=0
  - issue_ready=1
- Reset mid-operation discards all entries and any in-flight result.
- Latency with operands present and wb free: issue at edge E0.
  - Dispatch decision at E1; fu_en high in cycle E1–E2.
  - FU latches at E2; fu_finish high E2–E3.
  - Captured at E3; wb_valid high from E3.
- Throughput: at most one dispatch per 3 cycles, because FU finishes one cycle after its EN edge and the FU ignores EN while finishing.
- fu_en is never high on two consecutive cycles and is never high while BUSY except in its dispatch cycle.
- Simultaneous issue + snoop + dispatch on one edge are all legal and independent. A snoop never targets the entry being dispatched, which is already ready.

## Test plan
- Reset check: hold rst=0 then release. Required: all outputs 0, issue_ready=1; fu_finish=1 pulsed while IDLE gives wb_valid stays 0.
- Independent ADD: issue ctrl=0001, tag=3, qj=qk=0, vj=5, vk=7 at E0, wb_ready=1. Required: fu_en=1 only in E1–E2 with fu_a=5, fu_b=7; model returns 12; wb_valid=1, wb_tag=3, wb_data=12 from E3, cleared one cycle later.
- Dependency: issue tag=4, qj=6, vk=1, then cdb tag=6 data=10 two cycles later. Required: no fu_en before the CDB edge; fu_en the cycle after readiness with fu_a=10, fu_b=1.
- Same-edge bypass: issue with qk=9 while cdb_valid, tag=9, data=0xFFFF0000. Required: entry dispatched next edge with fu_b=0xFFFF0000.
- Full station: issue DEPTH entries all with qj=7. Required: issue_ready=0; an extra issue is dropped; a CDB tag=7 broadcast gives dispatches in index order, at most one per 3 cycles.
- Writeback backpressure: hold wb_ready=0 with two ready entries. Required: first result held stable in wb_*, no second fu_en; raising wb_ready gives consume, then the second dispatch on that same edge.
